// File: rtl/cnt_arb.sv
// Round-robin command arbiter sharing one loadable up/down counter among NREQ requesters.
// Optional abort of in-flight UP/DOWN runs is enabled by defining CNT_ARB_ABORT_EN.
module cnt_arb #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_cmd,
  input  logic [WIDTH*NREQ-1:0] req_arg,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_wrap,
`ifdef CNT_ARB_ABORT_EN
  input  logic                  abort,
  output logic                  rsp_abort,
`endif
  output logic                  cnt_rstn,
  output logic                  cnt_load_en,
  output logic [WIDTH-1:0]      cnt_load,
  output logic                  cnt_down,
  input  logic [WIDTH-1:0]      cnt_count
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_READ = 2'b11;

  // IDLE: arbitrate, counter held | LOAD: write arg | RUN: one step per cycle | RESP: report
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, id, pick;
  logic             found;
  logic [1:0]       cmd, pick_cmd;
  logic [WIDTH-1:0] arg, rem, pick_arg;
  logic             wrap_flag;
  logic             abort_now;
  logic             crossing;
  int               j;

`ifdef CNT_ARB_ABORT_EN
  logic abort_flag;
  assign abort_now = abort;
`else
  assign abort_now = 1'b0;
`endif

  assign cnt_rstn = ~rst;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
  end

  assign pick_cmd = req_cmd[2*int'(pick) +: 2];
  assign pick_arg = req_arg[WIDTH*int'(pick) +: WIDTH];
  assign crossing = ((cmd == CMD_UP) && (&cnt_count)) ||
                    ((cmd == CMD_DOWN) && (cnt_count == '0));

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    rsp_wrap    = 1'b0;
    cnt_load_en = 1'b0;
    cnt_load    = '0;
    cnt_down    = 1'b0;
`ifdef CNT_ARB_ABORT_EN
    rsp_abort   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_load_en = 1'b1;
        cnt_load    = cnt_count;
        if (found) begin
          req_ready[pick] = 1'b1;
          case (pick_cmd)
            CMD_LOAD: state_nxt = S_LOAD;
            CMD_UP, CMD_DOWN: state_nxt = (pick_arg != '0) ? S_RUN : S_RESP;
            default: state_nxt = S_RESP;
          endcase
        end
      end
      S_LOAD: begin
        cnt_load_en = 1'b1;
        cnt_load    = arg;
        state_nxt   = S_RESP;
      end
      S_RUN: begin
        cnt_down = (cmd == CMD_DOWN);
        if (abort_now) begin
          // Abort freezes the counter this cycle instead of taking a step.
          cnt_load_en = 1'b1;
          cnt_load    = cnt_count;
          state_nxt   = S_RESP;
        end else if (rem == WIDTH'(1)) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        cnt_load_en   = 1'b1;
        cnt_load      = cnt_count;
        rsp_valid[id] = 1'b1;
        rsp_data      = cnt_count;
        rsp_wrap      = wrap_flag;
`ifdef CNT_ARB_ABORT_EN
        rsp_abort     = abort_flag;
`endif
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (rst) begin
      req_ready   = '0;
      rsp_valid   = '0;
      rsp_data    = '0;
      rsp_wrap    = 1'b0;
      cnt_load_en = 1'b0;
      cnt_load    = '0;
      cnt_down    = 1'b0;
`ifdef CNT_ARB_ABORT_EN
      rsp_abort   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      id        <= '0;
      cmd       <= CMD_READ;
      arg       <= '0;
      rem       <= '0;
      wrap_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (found) begin
            id        <= pick;
            cmd       <= pick_cmd;
            arg       <= pick_arg;
            rem       <= pick_arg;
            ptr       <= (pick == IDW'(NREQ-1)) ? '0 : pick + 1'b1;
            wrap_flag <= 1'b0;
          end
        end
        S_RUN: begin
          if (!abort_now) begin
            rem <= rem - 1'b1;
            if (crossing) wrap_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CNT_ARB_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst)                          abort_flag <= 1'b0;
    else if (state == S_IDLE && found) abort_flag <= 1'b0;
    else if (state == S_RUN && abort)  abort_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_cnt_arb.sv
// Directed bench for cnt_arb with a behavioural model of the shared up/down counter.
// Abort checks are compiled in only when CNT_ARB_ABORT_EN is defined.
module tb_cnt_arb;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_cmd;
  logic [WIDTH*NREQ-1:0] req_arg;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_wrap;
  logic                  cnt_rstn;
  logic                  cnt_load_en;
  logic [WIDTH-1:0]      cnt_load;
  logic                  cnt_down;
  logic [WIDTH-1:0]      cnt_count;
`ifdef CNT_ARB_ABORT_EN
  logic                  abort;
  logic                  rsp_abort;
`endif

  int vec  = 0;
  int errs = 0;
  logic [3:0] grant_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  always #5 clk = ~clk;

  cnt_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_arg(req_arg),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_wrap(rsp_wrap),
`ifdef CNT_ARB_ABORT_EN
    .abort(abort), .rsp_abort(rsp_abort),
`endif
    .cnt_rstn(cnt_rstn), .cnt_load_en(cnt_load_en), .cnt_load(cnt_load),
    .cnt_down(cnt_down), .cnt_count(cnt_count)
  );

  // Shared counter: clears on rstn, loads when enabled, otherwise steps one per cycle.
  always_ff @(posedge clk) begin
    if (!cnt_rstn)        cnt_count <= '0;
    else if (cnt_load_en) cnt_count <= cnt_load;
    else if (cnt_down)    cnt_count <= cnt_count - 1'b1;
    else                  cnt_count <= cnt_count + 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from requester i in an IDLE cycle; returns in the T1 window.
  task automatic send(input int i, input logic [1:0] c, input logic [3:0] a);
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_cmd[2*i +: 2] = c;
    req_arg[4*i +: 4] = a;
    #1;
    chk("grant", req_ready, 32'(1 << i));
    cyc();
    req_valid = '0;
  endtask

  // Expect the response at T(lat); returns in the following IDLE window.
  task automatic wait_rsp(input int lat, input logic [3:0] v, input logic [3:0] d, input logic w);
    repeat (lat - 1) cyc();
    #1;
    chk("rsp_valid", rsp_valid, v);
    chk("rsp_data", rsp_data, d);
    chk("rsp_wrap", rsp_wrap, w);
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    req_arg = '0;
`ifdef CNT_ARB_ABORT_EN
    abort = 1'b0;
`endif

    // Reset state
    repeat (3) cyc();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_wrap", rsp_wrap, 0);
    chk("rst_load_en", cnt_load_en, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_down", cnt_down, 0);
    chk("rst_rstn", cnt_rstn, 0);
    chk("rst_count", cnt_count, 0);
`ifdef CNT_ARB_ABORT_EN
    chk("rst_rsp_abort", rsp_abort, 0);
`endif
    rst = 1'b0;

    send(0, 2'b11, 4'h0);
    wait_rsp(1, 4'b0001, 4'h0, 1'b0);

    // LOAD then UP across all-ones
    send(2, 2'b00, 4'hC);
    wait_rsp(2, 4'b0100, 4'hC, 1'b0);
    send(2, 2'b01, 4'h5);
    wait_rsp(6, 4'b0100, 4'h1, 1'b1);

    // LOAD then DOWN across zero, then zero-step DOWN
    send(1, 2'b00, 4'h2);
    wait_rsp(2, 4'b0010, 4'h2, 1'b0);
    send(1, 2'b10, 4'h3);
    wait_rsp(4, 4'b0010, 4'hF, 1'b1);
    send(1, 2'b10, 4'h0);
    wait_rsp(1, 4'b0010, 4'hF, 1'b0);

    // All requesters hold READ from reset
    rst = 1'b1;
    req_valid = 4'hF;
    req_cmd = 8'hFF;
    req_arg = '0;
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", req_ready, grant_order[k]);
      cyc();
      #1;
      chk("rr_rsp_valid", rsp_valid, grant_order[k]);
      chk("rr_rsp_data", rsp_data, 0);
      chk("rr_no_grant_in_resp", req_ready, 0);
      cyc();
    end

    // req3 busy in RUN while req0/req1 wait
    send(3, 2'b01, 4'hA);
    req_valid = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk("busy_no_grant", req_ready, 0);
      cyc();
    end
    #1;
    chk("busy_rsp_valid", rsp_valid, 4'b1000);
    chk("busy_rsp_data", rsp_data, 4'hA);
    chk("busy_resp_no_grant", req_ready, 0);
    cyc();
    #1;
    chk("wait_grant0", req_ready, 4'b0001);
    chk("idle_hold", cnt_count, 4'hA);
    cyc();
    req_valid[0] = 1'b0;
    #1;
    chk("wait_rsp0", rsp_valid, 4'b0001);
    chk("resp_hold", cnt_count, 4'hA);
    cyc();
    #1;
    chk("wait_grant1", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    #1;
    chk("wait_rsp1", rsp_valid, 4'b0010);
    chk("wait_rsp1_data", rsp_data, 4'hA);
    cyc();

`ifdef CNT_ARB_ABORT_EN
    send(0, 2'b00, 4'h0);
    wait_rsp(2, 4'b0001, 4'h0, 1'b0);
    send(0, 2'b01, 4'hA);
    cyc();
    cyc();
    cyc();
    abort = 1'b1;
    #1;
    chk("abort_hold", cnt_load_en, 1);
    cyc();
    abort = 1'b0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 4'b0001);
    chk("abort_rsp_data", rsp_data, 4'h3);
    chk("abort_flag", rsp_abort, 1);
    chk("abort_wrap", rsp_wrap, 0);
    cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
